fft16_sample_collector: RTL and testbench

//  Input deserialiser upstream of the 16-point FFT frame register bank.
//  - Accepts one complex sample per cycle on a valid/ready stream.
//  - Assembles 16 samples into a parallel frame.
//  - Presents the frame on flat buses, then raises frame_we.
//  - The register bank captures the frame on the rising edge of frame_we.

---
 rtl/fft16_sample_collector_if.sv | 12 +
 rtl/fft16_sample_collector.sv | 92 +++++++++
 tb/tb_fft16_sample_collector.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/fft16_sample_collector_if.sv
// Sample stream between the upstream source and the FFT16 sample collector.
interface fft16_sample_collector_if #(
    parameter int N = 16
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_re;
    logic [N-1:0] in_im;

    modport master (output in_valid, output in_re, output in_im, input  in_ready);
    modport slave  (input  in_valid, input  in_re, input  in_im, output in_ready);
endinterface

// File: rtl/fft16_sample_collector.sv
// Deserialises a complex sample stream into 16-sample frames for the FFT16 register bank.
// Build option COLLECTOR_BIT_REVERSE_EN stores arrivals in bit-reversed slot order.
module fft16_sample_collector #(
    parameter int N     = 16,
    parameter int FRAME = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    fft16_sample_collector_if.slave in_if,
    input  logic                    fft_busy_i,
    output logic [FRAME*N-1:0]      frame_re_o,
    output logic [FRAME*N-1:0]      frame_im_o,
    output logic                    frame_we_o,
    output logic [7:0]              frame_cnt_o
);
    typedef enum logic [1:0] {FILL, SETTLE, STROBE, HOLD} state_e;

    state_e     state_q, state_d;
    logic [3:0] idx_q, idx_d;
    logic [3:0] slot;
    logic       we_q, we_d;
    logic [7:0] cnt_q, cnt_d;
    logic       xfer;

    assign in_if.in_ready = (state_q == FILL);
    assign xfer           = in_if.in_valid & in_if.in_ready;

`ifdef COLLECTOR_BIT_REVERSE_EN
    assign slot = {idx_q[0], idx_q[1], idx_q[2], idx_q[3]};
`else
    assign slot = idx_q;
`endif

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        we_d    = 1'b0;
        cnt_d   = cnt_q;
        case (state_q)
            FILL: begin
                if (xfer) begin
                    idx_d = idx_q + 4'd1;
                    if (idx_q == 4'd15) state_d = SETTLE;
                end
            end
            SETTLE: begin
                // Strobe is registered, so it rises on the edge that enters STROBE.
                state_d = STROBE;
                we_d    = 1'b1;
                cnt_d   = cnt_q + 8'd1;
            end
            STROBE:  state_d = HOLD;
            HOLD:    if (!fft_busy_i) state_d = FILL;
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FILL;
            idx_q   <= 4'd0;
            we_q    <= 1'b0;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            we_q    <= we_d;
            cnt_q   <= cnt_d;
        end
    end

    // Slot registers only load during FILL, so the buses are frozen around the strobe.
    for (genvar s = 0; s < FRAME; s++) begin : g_slot
        logic [N-1:0] re_q, im_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                re_q <= '0;
                im_q <= '0;
            end else if (xfer && (slot == 4'(s))) begin
                re_q <= in_if.in_re;
                im_q <= in_if.in_im;
            end
        end

        assign frame_re_o[s*N +: N] = re_q;
        assign frame_im_o[s*N +: N] = im_q;
    end

    assign frame_we_o  = we_q;
    assign frame_cnt_o = cnt_q;
endmodule

// File: tb/tb_fft16_sample_collector.sv
// Directed bench for fft16_sample_collector: table of frames plus reset, strobe-reset and wrap sequences.
module tb_fft16_sample_collector;
    localparam int N = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             fft_busy;
    logic [16*N-1:0]  fre, fim;
    logic             fwe;
    logic [7:0]       fcnt;

    always #5 clk = ~clk;

    fft16_sample_collector_if #(.N(N)) sif ();

    fft16_sample_collector #(.N(N), .FRAME(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_if       (sif.slave),
        .fft_busy_i  (fft_busy),
        .frame_re_o  (fre),
        .frame_im_o  (fim),
        .frame_we_o  (fwe),
        .frame_cnt_o (fcnt)
    );

    int tests = 0;
    int fails = 0;
    int pulses = 0;
    int wide_err = 0;
    logic we_prev = 1'b0;
    logic [16*N-1:0] exp_re, exp_im;

    always @(negedge clk) begin
        if (fwe === 1'b1) begin
            pulses <= pulses + 1;
            if (we_prev === 1'b1) wide_err <= wide_err + 1;
        end
        we_prev <= fwe;
    end

    typedef struct {
        logic [15:0] bre;
        logic [15:0] bim;
        bit          gaps;
        int          busy;
        logic [7:0]  ecnt;
    } vec_t;

    vec_t tbl [4];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chkbus(input string nm, input logic [16*N-1:0] act, input logic [16*N-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic int slot_of(input int i);
`ifdef COLLECTOR_BIT_REVERSE_EN
        return ((i & 1) << 3) | ((i & 2) << 1) | ((i & 4) >> 1) | ((i & 8) >> 3);
`else
        return i;
`endif
    endfunction

    task automatic build(input logic [15:0] bre, input logic [15:0] bim, input int n);
        for (int i = 0; i < n; i++) begin
            exp_re[slot_of(i)*N +: N] = bre + 16'(i);
            exp_im[slot_of(i)*N +: N] = bim - 16'(i);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [15:0] bre, input logic [15:0] bim, input bit gaps,
                              input int busy, input logic [7:0] ecnt);
        int k, cyc, rbad;
        k = 0; cyc = 0; rbad = 0;
        fft_busy = (busy > 0);
        while (k < 16 && cyc < 200) begin
            sif.in_valid = gaps ? (cyc % 2 == 0) : 1'b1;
            sif.in_re    = bre + 16'(k);
            sif.in_im    = bim - 16'(k);
            if (sif.in_ready !== 1'b1) rbad++;
            step;
            if (sif.in_valid) k++;
            cyc++;
        end
        sif.in_valid = 1'b0;
        chk("fill_done", 32'(k), 32'd16);
        chk("fill_ready", 32'(rbad), 32'd0);
        chk("fill_cycles", 32'(cyc), gaps ? 32'd31 : 32'd16);
        build(bre, bim, 16);
        chk("settle_we", 32'(fwe), 32'd0);
        chk("settle_ready", 32'(sif.in_ready), 32'd0);
        step;
        chk("strobe_we", 32'(fwe), 32'd1);
        step;
        chk("hold_we", 32'(fwe), 32'd0);
        chk("frame_cnt", 32'(fcnt), 32'(ecnt));
        chkbus("frame_re", fre, exp_re);
        chkbus("frame_im", fim, exp_im);
        for (int b = 0; b < busy; b++) begin
            chk("busy_ready", 32'(sif.in_ready), 32'd0);
            step;
        end
        fft_busy = 1'b0;
        chk("hold_ready", 32'(sif.in_ready), 32'd0);
        step;
        chk("resume_ready", 32'(sif.in_ready), 32'd1);
        chkbus("held_re", fre, exp_re);
        chkbus("held_im", fim, exp_im);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] s1, s8, s15;
        int p0;

        tbl[0] = '{bre: 16'h0000, bim: 16'h0000, gaps: 1'b0, busy: 0,  ecnt: 8'd1};
        tbl[1] = '{bre: 16'h0000, bim: 16'h0000, gaps: 1'b1, busy: 0,  ecnt: 8'd2};
        tbl[2] = '{bre: 16'h1000, bim: 16'h0100, gaps: 1'b0, busy: 10, ecnt: 8'd3};
        tbl[3] = '{bre: 16'h7FF8, bim: 16'h8008, gaps: 1'b1, busy: 3,  ecnt: 8'd4};

        rst_n = 1'b0; fft_busy = 1'b0;
        sif.in_valid = 1'b0; sif.in_re = '0; sif.in_im = '0;
        exp_re = '0; exp_im = '0;
        repeat (3) @(posedge clk);
        #1;
        chkbus("rst_re", fre, '0);
        chkbus("rst_im", fim, '0);
        chk("rst_we", 32'(fwe), 32'd0);
        chk("rst_cnt", 32'(fcnt), 32'd0);
        chk("rst_ready", 32'(sif.in_ready), 32'd1);
        @(negedge clk) rst_n = 1'b1;
        step;

        for (int t = 0; t < 4; t++) begin
            send_frame(tbl[t].bre, tbl[t].bim, tbl[t].gaps, tbl[t].busy, tbl[t].ecnt);
            if (t == 0) begin
                s1 = fre[1*N +: N]; s8 = fre[8*N +: N]; s15 = fre[15*N +: N];
`ifdef COLLECTOR_BIT_REVERSE_EN
                chk("slot1", 32'(s1), 32'd8);
                chk("slot8", 32'(s8), 32'd1);
`else
                chk("slot1", 32'(s1), 32'd1);
                chk("slot8", 32'(s8), 32'd8);
`endif
                chk("slot15", 32'(s15), 32'd15);
            end
        end

        // Partial frame keeps old slots, then reset discards it.
        for (int k = 0; k < 5; k++) begin
            sif.in_valid = 1'b1;
            sif.in_re    = 16'h0A00 + 16'(k);
            sif.in_im    = 16'h0B00 - 16'(k);
            step;
        end
        sif.in_valid = 1'b0;
        build(16'h0A00, 16'h0B00, 5);
        chkbus("partial_re", fre, exp_re);
        chkbus("partial_im", fim, exp_im);
        chk("partial_ready", 32'(sif.in_ready), 32'd1);
        rst_n = 1'b0;
        #2;
        chkbus("midrst_re", fre, '0);
        chkbus("midrst_im", fim, '0);
        chk("midrst_cnt", 32'(fcnt), 32'd0);
        chk("midrst_ready", 32'(sif.in_ready), 32'd1);
        @(negedge clk) rst_n = 1'b1;
        step;
        exp_re = '0; exp_im = '0;
        send_frame(16'h0100, 16'h0200, 1'b0, 0, 8'd1);

        // Reset while the strobe is high.
        for (int k = 0; k < 16; k++) begin
            sif.in_valid = 1'b1;
            sif.in_re    = 16'(k);
            sif.in_im    = 16'(k);
            step;
        end
        sif.in_valid = 1'b0;
        step;
        chk("pre_rst_we", 32'(fwe), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("strobe_rst_we", 32'(fwe), 32'd0);
        chk("strobe_rst_cnt", 32'(fcnt), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        step;

        // 256 back-to-back frames wrap the counter.
        exp_re = '0; exp_im = '0;
        p0 = pulses;
        for (int f = 0; f < 256; f++)
            send_frame(16'(f), 16'(f * 3), 1'b0, 0, 8'(f + 1));
        step;
        chk("wrap_cnt", 32'(fcnt), 32'd0);
        chk("wrap_pulses", 32'(pulses - p0), 32'd256);
        chk("pulse_width", 32'(wide_err), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
